// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Holds each grant until tx_done or a watchdog abort, then rotates priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 60000
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_done,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_done,
  output logic                          o_busy,
  output logic                          o_timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW:0]   NR   = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  r_state, w_state;
  logic [IW-1:0]           r_grant, w_grant;
  logic [IW-1:0]           r_ptr, w_ptr;
  logic [CW-1:0]           r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0]   r_data, w_data;
  logic [NUM_REQ-1:0]      r_ack, w_ack;
  logic [NUM_REQ-1:0]      r_done, w_done;
  logic                    r_start, w_start;
  logic                    r_terr, w_terr;

  logic [IW:0]             w_k;
  logic                    w_found;
  logic [IW-1:0]           w_sel;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [IW-1:0]           w_ptr_nxt;
  logic [NUM_REQ-1:0]      w_gmask;

  // Scan requesters starting at ptr, wrapping at NUM_REQ.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_sel_data = '0;
    w_k        = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_k = {1'b0, r_ptr} + (IW+1)'(j);
      if (w_k >= NR) w_k = w_k - NR;
      if (!w_found && i_req[w_k[IW-1:0]]) begin
        w_found    = 1'b1;
        w_sel      = w_k[IW-1:0];
        w_sel_data = i_req_data[w_k[IW-1:0]*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (r_grant == LAST) ? '0 : r_grant + 1'b1;
  assign w_gmask   = NUM_REQ'(1) << r_grant;

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    w_data  = r_data;
    w_ack   = '0;
    w_done  = '0;
    w_start = 1'b0;
    w_terr  = r_terr;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant = w_sel;
          w_data  = w_sel_data;
          w_cnt   = '0;
          w_ack   = NUM_REQ'(1) << w_sel;
          w_start = 1'b1;
          w_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // tx_done outranks the watchdog when both land together
        if (r_cnt != '0 && i_tx_done) begin
          w_done  = w_gmask;
          w_ptr   = w_ptr_nxt;
          w_state = S_IDLE;
        end else if (r_cnt == TMAX) begin
          w_terr  = 1'b1;
          w_done  = w_gmask;
          w_ptr   = w_ptr_nxt;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_data  <= w_data;
      r_ack   <= w_ack;
      r_done  <= w_done;
      r_start <= w_start;
      r_terr  <= w_terr;
    end
  end

  assign o_ack         = r_ack;
  assign o_done        = r_done;
  assign o_tx_start    = r_start;
  assign o_tx_data     = r_data;
  assign o_busy        = (r_state == S_WAIT);
  assign o_timeout_err = r_terr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter (3 requesters, short watchdog).
module tb_uart_tx_arbiter;
  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int TO    = 16;
  localparam int NEVER = -1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            tx_done = 1'b0;
  logic [N-1:0]    ack, done;
  logic            tx_start, busy, terr;
  logic [DW-1:0]   tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_req_data(req_data),
    .o_ack(ack), .o_done(done), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_done(tx_done), .o_busy(busy), .o_timeout_err(terr)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            lat;
    logic          err;
    logic          gap1;
  } exp_t;

  exp_t exp_q[$];
  int   dq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_off = 1'b0;
  bit   in_flight = 1'b0;
  exp_t cur;
  int   age = 0;
  int   since_done = 1000;
  logic prev_busy = 1'b0;
  int   batch_id = 0;
  int   seen_id = 0;
  logic [N-1:0]    b_mask = '0;
  logic [N*DW-1:0] b_data = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requesters: load a batch of level requests, drop each on its ack.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (ack[i]) begin
        req[i] = 1'b0;
        req_data[i*DW +: DW] = DW'($urandom);
      end
    if (batch_id != seen_id) begin
      seen_id  = batch_id;
      req      = b_mask;
      req_data = b_data;
    end
  end

  // Transmitter stand-in: answers each tx_start after a queued delay.
  initial forever begin
    int d;
    bit spur;
    @(negedge clk);
    if (tx_start) begin
      d = (dq.size() > 0) ? dq.pop_front() : NEVER;
      spur = 1'($urandom_range(0, 1));
      tx_done = spur;
      @(posedge clk); #1 tx_done = 1'b0;
      if (d != NEVER) begin
        repeat (d - 1) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops the expected grant on every ack and times its done.
  always @(negedge clk) begin
    if (!mon_off) begin
      since_done++;
      if (|ack) begin
        chk("ack_onehot", 32'($onehot0(ack)), 1);
        if (exp_q.size() == 0) chk("unexpected_ack", 32'(ack), 0);
        else begin
          cur = exp_q.pop_front();
          chk("ack_idx", 32'(ack), 32'(1) << cur.idx);
          chk("tx_start", 32'(tx_start), 1);
          chk("busy_on_ack", 32'(busy), 1);
          chk("tx_data", 32'(tx_data), 32'(cur.data));
          chk("idle_before_ack", 32'(prev_busy), 0);
          if (cur.gap1) chk("one_cycle_gap", since_done, 1);
          in_flight = 1'b1;
          age = 0;
        end
      end else if (in_flight) begin
        age++;
        if (|done) begin
          chk("done_idx", 32'(done), 32'(1) << cur.idx);
          chk("done_latency", age, cur.lat);
          chk("timeout_err", 32'(terr), 32'(cur.err));
          chk("busy_on_done", 32'(busy), 0);
          chk("tx_data_hold", 32'(tx_data), 32'(cur.data));
          in_flight = 1'b0;
          since_done = 0;
        end else if (age > cur.lat) begin
          chk("done_missing", age, cur.lat);
          in_flight = 1'b0;
        end
      end else if (|done) begin
        chk("unexpected_done", 32'(done), 0);
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || in_flight || req != '0 ||
            batch_id != seen_id) && w < 600) begin
      @(posedge clk);
      w++;
    end
    if (w >= 600) chk("idle_wait_expired", w, 0);
  endtask

  task automatic wait_ack(output int w);
    w = 0;
    while (ack == '0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (w >= 60) chk("ack_wait_expired", w, 0);
  endtask

  initial begin
    int              k, r, d, last, w, model_ptr;
    bit              first, model_err, saw;
    logic [N-1:0]    mask;
    logic [N*DW-1:0] data;
    exp_t            e;

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_err", 32'(terr), 0);
    @(posedge clk); #1 rst = 1'b0;

    model_ptr = 0;
    model_err = 1'b0;
    last = 0;
    for (int b = 0; b < 40; b++) begin
      wait_idle();
      mask  = N'($urandom_range(1, (1 << N) - 1));
      data  = (N*DW)'({$urandom, $urandom});
      first = 1'b1;
      for (int j = 0; j < N; j++) begin
        k = (model_ptr + j) % N;
        if (mask[k]) begin
          r = $urandom_range(0, 9);
          d = (r == 0) ? NEVER : (r == 1) ? TO : $urandom_range(1, TO - 1);
          if (d == NEVER) model_err = 1'b1;
          e.idx  = k;
          e.data = data[k*DW +: DW];
          e.lat  = (d == NEVER) ? TO + 1 : d + 1;
          e.err  = model_err;
          e.gap1 = !first;
          first  = 1'b0;
          exp_q.push_back(e);
          dq.push_back(d);
          last = k;
        end
      end
      model_ptr = (last + 1) % N;
      b_mask = mask;
      b_data = data;
      batch_id++;
    end
    wait_idle();

    mon_off = 1'b1;
    dq.push_back(NEVER);
    dq.push_back(NEVER);
    b_mask = 3'b010;
    b_data = (N*DW)'($urandom);
    batch_id++;
    wait_ack(w);
    chk("rp_first_ack", 32'(ack), 32'b010);
    repeat (4) @(posedge clk);
    #3;
    chk("rp_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rp_busy", 32'(busy), 0);
    chk("rp_tx_data", 32'(tx_data), 0);
    chk("rp_timeout_err", 32'(terr), 0);
    chk("rp_ack_done_start", 32'({ack, done, tx_start}), 0);
    @(posedge clk); #1 rst = 1'b0;
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (|done) saw = 1'b1;
    end
    chk("rp_no_done", 32'(saw), 0);
    b_mask = 3'b110;
    b_data = (N*DW)'($urandom);
    batch_id++;
    wait_ack(w);
    chk("rp_lowest_grant", 32'(ack), 32'b010);
    chk("rp_grant_data", 32'(tx_data), 32'(b_data[DW +: DW]));
    w = 0;
    while (done == '0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("rp_watchdog_done", 32'(done), 32'b010);
    chk("rp_watchdog_lat", w, TO + 1);
    chk("rp_watchdog_err", 32'(terr), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `transmitter_system` UART transmitter between `NUM_REQ` independent byte producers. It accepts one byte at a time from a requester and drives `tx_start`/`data_in` into the transmitter. It holds the grant until the transmitter reports `tx_done` or a watchdog expires, then rotates priority. It sits between the requesting blocks and the transmitter, in the same clock domain.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2, need not be a power of two.
- `DATA_WIDTH`, 8: byte width; must match the transmitter `DATA_WIDTH`.
- `TIMEOUT`, 60000: watchdog limit in clock cycles, > one 10-bit frame at the configured baud rate (10×5209 = 52090).
- `clock`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset; drives the same reset net as the transmitter.
- `req`  in  NUM_REQ  level request; bit i is held by requester i until `ack[i]`.
- `req_data`  in  NUM_REQ×DATA_WIDTH  byte of requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`; valid while `req[i]` is high.
- `ack`  out  NUM_REQ  one-cycle pulse; the byte of requester i has been latched.
- `done`  out  NUM_REQ  one-cycle pulse; the frame of requester i has finished or been aborted.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_WIDTH  latched byte to the transmitter `data_in`; stable for the whole grant.
- `tx_done`  in  1  transmitter frame-complete pulse.
- `busy`  out  1  high while a grant is outstanding (state WAIT).
- `timeout_err`  out  1  sticky; set on a watchdog abort; cleared only by `reset`.

## Operation
- State machine with two states.
  - IDLE: no grant outstanding.
  - WAIT: one frame is in flight.
- Registers:
  - `state`
  - `grant_idx`: width clog2(NUM_REQ)
  - `ptr`: round-robin pointer, same width
  - `cnt`: watchdog counter, width clog2(TIMEOUT+1)
  - `tx_data`, `ack`, `done`, `tx_start`, `timeout_err`
- IDLE with no `req` bit set: stay in IDLE. All pulse outputs are 0.
- IDLE with any `req` bit set:
  - Select the first set bit in order ptr, ptr+1, …, NUM_REQ−1, 0, …, ptr−1.
  - Latch `grant_idx` and `tx_data ← req_data[grant_idx]`; clear `cnt`.
  - Pulse `ack[grant_idx]` and `tx_start`; go to WAIT.
- WAIT, cnt ≥ 1 and `tx_done` = 1:
  - Pulse `done[grant_idx]`.
  - Set `ptr ← (grant_idx+1) mod NUM_REQ`, wrapping at NUM_REQ and not at 2^width.
  - Go to IDLE.
- WAIT, cnt = TIMEOUT and `tx_done` = 0:
  - Set `timeout_err`, pulse `done[grant_idx]`, advance `ptr` as above, go to IDLE.
- WAIT otherwise: `cnt ← cnt+1`; saturation is never reached.
- `tx_done` is ignored in IDLE and in the first WAIT cycle (cnt = 0, the `tx_start` cycle).
- `req[i]` still high in the cycle after `ack[i]` is treated as a new request at the next arbitration. Requesters must drop `req` on `ack` if they have only one byte.
- `req_data` is sampled only at the granting edge. Later changes do not affect `tx_data`.
- At most one bit of `ack` and of `done` is ever high.

## Timing
- Reset values: state IDLE, `ptr` 0, `ack` 0, `done` 0, `tx_start` 0, `tx_data` 0, `busy` 0, `timeout_err` 0.
- Reset is asynchronous: taking effect mid-WAIT returns the block to IDLE immediately. No `done` pulse is issued for the aborted frame.
- `req` high at edge k (state IDLE): `ack`, `tx_start` and `busy` are high in cycle k+1, and `tx_data` is valid from cycle k+1.
- `tx_done` sampled high at edge t+m (m ≥ 1, with t the `tx_start` cycle): `done` is high and `busy` low in cycle t+m+1. The earliest next `ack` is cycle t+m+2, giving a one-cycle IDLE gap between grants.
- Watchdog abort: `done` and `timeout_err` go high in cycle t+TIMEOUT+1.
- Simultaneous `tx_done` and watchdog expiry: `tx_done` wins and `timeout_err` is not set.

## Test plan
- Single requester: `req[2]`=1 with byte 0xA5. Expect `ack[2]` and `tx_start` one cycle later, `tx_data`=0xA5, `busy`=1. Inject `tx_done` 20 cycles later. Expect `done[2]` next cycle, `busy`=0, `ptr`=3.
- Contention: `req`=4'b1011 held continuously from reset, `tx_done` returned 10 cycles after each `tx_start`. Expect grant order 0, 1, 3, 0, 1, 3, each `ack` preceded by exactly one idle cycle.
- Wrap with non-power-of-two count: NUM_REQ=3, `req`=3'b111. Expect grant order 0, 1, 2, 0, and `ptr` never reaching 3.
- Watchdog: TIMEOUT=16, `tx_done` held 0. Expect `done` and `timeout_err`=1 exactly 17 cycles after `tx_start`. The next request is served normally and `timeout_err` stays 1. A `tx_done` arriving exactly at cnt=16 gives `timeout_err`=0.
- Reset mid-frame: assert `reset` for 1 cycle during WAIT. All outputs go to 0 asynchronously, no `done` pulse, and the next grant goes to the lowest set `req` bit.
- System: connect to `transmitter_system` (LIMIT 5209), with requesters 0 and 1 sending 0x55 and 0x0F. Expect two back-to-back serial frames in that order and `timeout_err`=0.
